// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared constants and types for the instruction-fetch stage.
//   XLEN          default address/PC width (the struct layout below uses it)
//   INST_W        instruction word width
//   NOP_INST      canonical RISC-V NOP (addi x0, x0, 0)
//   fetch_entry_t one prefetch FIFO entry: {pc, inst}
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int XLEN   = 32;
    localparam int INST_W = 32;

    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage : fetch_pkg

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Registered prefetch FIFO between the instruction memory response path and
// decode. There is no bypass: a pushed word becomes visible at dout one cycle
// after the push. dout reads 0 when the FIFO is empty.
// Parameters: WIDTH (entry width), DEPTH (entries, power of 2, >= 2)
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   push, din   write one entry (ignored while flush is high)
//   pop         release the head entry
//   flush       empty the FIFO; wins over push and pop
//   dout        head entry
//   count       occupancy, 0..DEPTH
//   empty, full occupancy flags
// -----------------------------------------------------------------------------
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push && !flush && !full;
    assign do_pop  = pop && !flush && !empty;
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // NOTE: storage has no reset; count/empty gate every read, so stale
    // contents are never observed and the array can map onto plain flops/RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule : fetch_fifo

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage. Issues in-order word fetches to a valid/ready
// instruction memory with up to MAX_OUTSTANDING requests in flight, buffers the
// returned words with their PCs in a prefetch FIFO, and serves decode through a
// valid/ready interface. Trap/mret and branch redirects flush the FIFO and
// discard responses that were already in flight.
//
// Optional feature: define FETCH_PERF_CNT_EN to add the saturating 32-bit
// performance counters perf_redir_cnt and perf_starve_cnt.
//
// Parameters: XLEN, FIFO_DEPTH (power of 2, >= 2),
//             MAX_OUTSTANDING (1..FIFO_DEPTH), RESET_PC
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   trap_redir, trap_pc              CSR redirect (trap entry / mret)
//   br_redir, br_pc                  taken branch/jump redirect from decode
//   imem_req_valid/ready/addr        fetch request channel
//   imem_rsp_valid/data              in-order response channel, no backpressure
//   if_valid/ready, if_pc/if_inst    instruction presented to decode
//   fetch_idle                       nothing in flight, nothing to drop, FIFO empty
//   perf_redir_cnt, perf_starve_cnt  (FETCH_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN            = 32,
    parameter int              FIFO_DEPTH      = 4,
    parameter int              MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trap_redir,
    input  logic [XLEN-1:0]   trap_pc,
    input  logic              br_redir,
    input  logic [XLEN-1:0]   br_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [XLEN-1:0]   if_pc,
    output logic [INST_W-1:0] if_inst,
    output logic              fetch_idle
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_redir_cnt,
    output logic [31:0]       perf_starve_cnt
`endif
);

    localparam int OUT_W   = $clog2(MAX_OUTSTANDING+1);
    localparam int CNT_W   = $clog2(FIFO_DEPTH+1);
    localparam int SUM_W   = CNT_W + 1;
    localparam int ENTRY_W = XLEN + INST_W;

    logic [XLEN-1:0]    fetch_pc;
    logic [XLEN-1:0]    rsp_pc;
    logic [OUT_W-1:0]   outstanding;
    logic [OUT_W-1:0]   drop_cnt;

    logic               redir;
    logic [XLEN-1:0]    target;
    logic [SUM_W-1:0]   in_use;
    logic               req_fire;
    logic               rsp_ok;
    logic               dropping;
    logic               push;
    logic               pop;

    logic [ENTRY_W-1:0] fifo_dout;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_empty;
    logic               fifo_full;

    // NOTE: every variable driven here gets a value before any condition,
    // so no path through the block leaves it unassigned (no latch).
    always_comb begin
        redir       = trap_redir | br_redir;
        target      = trap_redir ? trap_pc : br_pc;
        target[1:0] = 2'b00;
    end

    // Credit rule: a request is only issued if a FIFO slot is already reserved
    // for its response, which is why the response path needs no backpressure.
    assign in_use         = SUM_W'(outstanding) + SUM_W'(fifo_count);
    assign imem_req_valid = !rst && !redir
                            && (outstanding < OUT_W'(MAX_OUTSTANDING))
                            && (in_use < SUM_W'(FIFO_DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_ok   = imem_rsp_valid && (outstanding != '0);
    assign dropping = (drop_cnt != '0);
    assign push     = rsp_ok && !redir && !dropping;

    assign if_valid = !fifo_empty && !redir;
    assign pop      = if_valid && if_ready;
    assign if_pc    = fifo_dout[ENTRY_W-1:INST_W];
    assign if_inst  = fifo_dout[INST_W-1:0];

    assign fetch_idle = (outstanding == '0) && !dropping && fifo_empty;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (redir) begin
            // No request fires in a redirect cycle. Everything still in
            // flight afterwards is stale; a response arriving now is dropped
            // directly, so it is not counted again.
            fetch_pc    <= target;
            rsp_pc      <= target;
            outstanding <= outstanding - OUT_W'(rsp_ok);
            drop_cnt    <= outstanding - OUT_W'(rsp_ok);
        end else begin
            if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
            if (push)     rsp_pc   <= rsp_pc + XLEN'(4);
            if (rsp_ok && dropping) drop_cnt <= drop_cnt - OUT_W'(1);
            if (req_fire && !rsp_ok)      outstanding <= outstanding + OUT_W'(1);
            else if (!req_fire && rsp_ok) outstanding <= outstanding - OUT_W'(1);
        end
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redir),
        .din   ({rsp_pc, imem_rsp_data}),
        .dout  (fifo_dout),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_redir_cnt  <= '0;
            perf_starve_cnt <= '0;
        end else begin
            if (redir && (perf_redir_cnt != '1))
                perf_redir_cnt <= perf_redir_cnt + 32'd1;
            if (if_ready && !if_valid && !redir && (perf_starve_cnt != '1))
                perf_starve_cnt <= perf_starve_cnt + 32'd1;
        end
    end
`endif

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && fifo_full))
        else $error("fetch_unit: push into full prefetch FIFO");

    a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
        !(imem_rsp_valid && (outstanding == '0)))
        else $error("fetch_unit: response with no outstanding request");

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit (FIFO_DEPTH=4, MAX_OUTSTANDING=2,
// RESET_PC=0x100). A behavioural memory returns inst_of(addr) after a chosen
// latency. The reference model tracks program order at transaction level:
// every request is tagged with the redirect epoch it was issued in, only
// current-epoch words count as buffered, and decode must see consecutive PCs
// from the last redirect target (or RESET_PC) with matching instruction words.
// -----------------------------------------------------------------------------
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int          DEPTH = 4;
    localparam int          MAXO  = 2;
    localparam logic [31:0] RPC   = 32'h100;

    logic        clk;
    logic        rst;
    logic        trap_redir;
    logic [31:0] trap_pc;
    logic        br_redir;
    logic [31:0] br_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        fetch_idle;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_redir_cnt;
    logic [31:0] perf_starve_cnt;
`endif

    fetch_unit #(
        .XLEN            (32),
        .FIFO_DEPTH      (DEPTH),
        .MAX_OUTSTANDING (MAXO),
        .RESET_PC        (RPC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .trap_redir     (trap_redir),
        .trap_pc        (trap_pc),
        .br_redir       (br_redir),
        .br_pc          (br_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .fetch_idle     (fetch_idle)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_redir_cnt  (perf_redir_cnt),
        .perf_starve_cnt (perf_starve_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model state ----------------
    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } mreq_t;

    mreq_t       mq[$];          // requests accepted by memory, in order
    int          epoch;          // bumps on every redirect
    int          buffered;       // current-epoch words waiting for decode
    logic [31:0] exp_req_addr;   // next address the fetcher must request
    logic [31:0] exp_pc;         // next PC decode must see
    logic [31:0] exp_redir_cnt;
    logic [31:0] exp_starve_cnt;
    int          cyc;

    // stimulus knobs
    logic        want_trap, want_br;
    logic [31:0] want_trap_pc, want_br_pc;
    int          rdy_pct, req_rdy_pct, lat_min, lat_max;

    int n_checks;
    int n_errors;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: drive at negedge, check 1 ns later, update model at posedge.
    task automatic cycle();
        logic        redir, exp_req_valid, exp_if_valid, fire, rsp, is_trap;
        logic [31:0] tgt;
        mreq_t       head;

        @(negedge clk);
        trap_redir     = want_trap;
        trap_pc        = want_trap_pc;
        br_redir       = want_br;
        br_pc          = want_br_pc;
        want_trap      = 1'b0;
        want_br        = 1'b0;
        if_ready       = ($urandom_range(99) < rdy_pct);
        imem_req_ready = ($urandom_range(99) < req_rdy_pct);
        rsp            = (mq.size() > 0) && (mq[0].due <= cyc);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? inst_of(mq[0].addr) : $urandom;
        #1;

        redir         = trap_redir | br_redir;
        is_trap       = trap_redir;
        exp_req_valid = !redir && (mq.size() < MAXO) && ((mq.size() + buffered) < DEPTH);
        exp_if_valid  = !redir && (buffered > 0);

        check("req_valid", {31'd0, imem_req_valid}, {31'd0, exp_req_valid});
        if (exp_req_valid) check("req_addr", imem_req_addr, exp_req_addr);
        check("if_valid", {31'd0, if_valid}, {31'd0, exp_if_valid});
        if (exp_if_valid) begin
            check("if_pc", if_pc, exp_pc);
            check("if_inst", if_inst, inst_of(exp_pc));
        end
        check("idle", {31'd0, fetch_idle}, {31'd0, (mq.size() == 0 && buffered == 0)});
`ifdef FETCH_PERF_CNT_EN
        check("perf_redir", perf_redir_cnt, exp_redir_cnt);
        check("perf_starve", perf_starve_cnt, exp_starve_cnt);
`endif
        fire = exp_req_valid && imem_req_ready;

        @(posedge clk);
        if (redir) begin
            tgt          = is_trap ? trap_pc : br_pc;
            tgt[1:0]     = 2'b00;
            epoch++;
            buffered     = 0;
            exp_req_addr = tgt;
            exp_pc       = tgt;
            if (rsp) head = mq.pop_front();
            exp_redir_cnt++;
        end else begin
            if (rsp) begin
                head = mq.pop_front();
                if (head.epoch == epoch) buffered++;
            end
            if (exp_if_valid && if_ready) begin
                buffered--;
                exp_pc += 32'd4;
            end
            if (fire) begin
                mq.push_back('{addr: exp_req_addr, epoch: epoch,
                               due: cyc + int'($urandom_range(lat_max, lat_min))});
                exp_req_addr += 32'd4;
            end
            if (if_ready && !exp_if_valid) exp_starve_cnt++;
        end
        cyc++;
    endtask

    // Run until n requests are in flight, bounded.
    task automatic wait_inflight(input int n);
        int i;
        i = 0;
        while (mq.size() != n && i < 50) begin
            cycle();
            i++;
        end
        check("wait_inflight", {31'd0, (mq.size() == n)}, 32'd1);
    endtask

    initial begin
        n_checks = 0; n_errors = 0; cyc = 0;
        epoch = 0; buffered = 0;
        exp_req_addr = RPC; exp_pc = RPC;
        exp_redir_cnt = '0; exp_starve_cnt = '0;
        want_trap = 0; want_br = 0; want_trap_pc = '0; want_br_pc = '0;
        rdy_pct = 100; req_rdy_pct = 100; lat_min = 1; lat_max = 1;

        rst = 1'b1;
        trap_redir = 0; trap_pc = '0; br_redir = 0; br_pc = '0;
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0; if_ready = 0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_if_valid", {31'd0, if_valid}, 32'd0);
        check("rst_if_pc", if_pc, 32'd0);
        check("rst_if_inst", if_inst, 32'd0);
        check("rst_idle", {31'd0, fetch_idle}, 32'd1);
`ifdef FETCH_PERF_CNT_EN
        check("rst_perf_redir", perf_redir_cnt, 32'd0);
        check("rst_perf_starve", perf_starve_cnt, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Streaming, 1-cycle memory, decode always ready.
        repeat (30) cycle();

        // Decode stalls: FIFO fills to DEPTH and requests stop; order on release.
        rdy_pct = 0;
        repeat (10) cycle();
        rdy_pct = 100;
        repeat (10) cycle();

        // Branch with two requests in flight on a 3-cycle memory.
        lat_min = 3; lat_max = 3;
        wait_inflight(2);
        want_br = 1; want_br_pc = 32'h200;
        repeat (20) cycle();

        // Trap and branch together: trap wins.
        wait_inflight(2);
        want_trap = 1; want_trap_pc = 32'h80;
        want_br   = 1; want_br_pc   = 32'h300;
        repeat (15) cycle();

        // Second redirect while the first is still dropping stale words.
        wait_inflight(2);
        want_br = 1; want_br_pc = 32'h500;
        cycle();
        want_br = 1; want_br_pc = 32'h400;
        repeat (20) cycle();

        // PC wrap-around.
        lat_min = 1; lat_max = 1;
        want_br = 1; want_br_pc = 32'hFFFF_FFF8;
        repeat (12) cycle();

        // Memory refuses requests: unit goes idle after the redirect.
        req_rdy_pct = 0;
        want_trap = 1; want_trap_pc = 32'h600;
        repeat (8) cycle();

        // Random traffic: latencies, handshakes, redirects with unaligned targets.
        lat_min = 1; lat_max = 4; rdy_pct = 70; req_rdy_pct = 70;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) < 4) begin
                want_trap = $urandom_range(1);
                want_br   = !want_trap || ($urandom_range(1) == 1);
                want_trap_pc = $urandom;
                want_br_pc   = $urandom;
            end
            cycle();
        end
        want_trap = 0; want_br = 0;
        rdy_pct = 100; req_rdy_pct = 100;
        repeat (20) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fetch_unit
